pipe_skid_stage: RTL and testbench
==================================

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 64, payload width ({pc, instruction} for IF/ID use).
REQ-002 SHALL have parameter FLUSH_ZERO, default 1; 1 zeroes stored payload on flush, 0 only clears valid.
REQ-003 SHALL have parameter CNT_W, default 16, width of the drop counter.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_i  in  1  reset; synchronous, active-high.
REQ-006 stall_i  in  1  freeze stage; highest priority after reset.
REQ-007 flush_i  in  1  discard all held entries; below stall.
REQ-008 in_valid_i  in  1  upstream entry offered.
REQ-009 in_data_i  in  DATA_W  upstream payload.
REQ-010 in_bubble_i  in  1  offered entry is bogus (e.g. icache miss); carried as sideband.
REQ-011 in_ready_o  out  1  stage can accept this cycle.
REQ-012 out_valid_o  out  1  head entry presented downstream.
REQ-013 out_data_o  out  DATA_W  head payload.
REQ-014 out_bubble_o  out  1  head entry bubble flag.
REQ-015 out_ready_i  in  1  downstream accepts head.
REQ-016 occupancy_o  out  2  entries held (0..2).
REQ-017 drop_cnt_o  out  CNT_W  saturating count of entries discarded by flush.

Function
REQ-018 SHALL hold up to two entries: main (head) and skid; each entry = payload + bubble flag.
REQ-019 SHALL implement states EMPTY, ONE, FULL; occupancy_o = 0/1/2 respectively, registered.
REQ-020 in_ready_o SHALL equal (state != FULL) & !stall_i & !flush_i; out_valid_o SHALL equal (state != EMPTY) & !stall_i & !flush_i.
REQ-021 accept = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
REQ-022 EMPTY: accept -> ONE, main <= input; else stay.
REQ-023 ONE: accept & pop -> ONE, main <= input; accept & !pop -> FULL, skid <= input; pop & !accept -> EMPTY; neither -> stay.
REQ-024 FULL: pop -> ONE, main <= skid; no accept possible; else stay.
REQ-025 Entries SHALL leave in acceptance order; one-cycle latency from accept (EMPTY) to out_valid_o.
REQ-026 out_data_o/out_bubble_o SHALL be driven from main register only, with no combinational path from in_data_i.
REQ-027 stall_i = 1 SHALL freeze all state and counters regardless of flush_i, in_valid_i and out_ready_i.
REQ-028 flush_i = 1 with stall_i = 0 SHALL move to EMPTY next cycle; with FLUSH_ZERO = 1, main and skid payload and bubble SHALL become 0.
REQ-029 On flush, drop_cnt_o SHALL add current occupancy (0..2), saturating at 2^CNT_W-1.
REQ-030 Bubble entries SHALL occupy slots and handshake exactly as valid entries; no filtering.
REQ-031 Payload registers SHALL load only on the transitions listed in REQ-022..024 or flush.

Reset
REQ-032 rst_i = 1 at a rising edge SHALL force EMPTY, main/skid payload and bubble = 0, drop_cnt_o = 0, overriding stall and flush.
REQ-033 Reset mid-transfer SHALL discard held entries without incrementing drop_cnt_o.
REQ-034 After reset, in_ready_o = 1 and out_valid_o = 0 when stall_i = flush_i = 0.

Structure
REQ-035 Package pipe_pkg SHALL hold the state typedef (EMPTY/ONE/FULL) and occupancy width constant (2).
REQ-036 Entry storage SHALL be one sub-module pipe_entry_reg (DATA_W payload + bubble, load enable, zero enable, sync reset), instantiated twice.

Verification
REQ-037 Reset, then in_valid_i = 1, data 0x1, out_ready_i = 1 -> out_valid_o = 1, out_data_o = 0x1 next cycle, occupancy_o = 1.
REQ-038 out_ready_i = 0, push 0xA, 0xB -> occupancy_o = 2, in_ready_o = 0; release ready -> 0xA then 0xB on consecutive cycles.
REQ-039 FULL, assert stall_i and flush_i together -> state, data, drop_cnt_o unchanged; out_valid_o = in_ready_o = 0.
REQ-040 FULL, flush_i alone, FLUSH_ZERO = 1 -> EMPTY, out_data_o = 0, drop_cnt_o += 2; 2^CNT_W flushes of FULL -> drop_cnt_o saturates at 0xFFFF.
REQ-041 Push 0x5 with in_bubble_i = 1 -> out_bubble_o = 1 with out_data_o = 0x5; rst_i while FULL -> EMPTY, drop_cnt_o = 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and widths for the two-entry pipeline skid stage.
package pipe_pkg;

  localparam int unsigned OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: payload plus bubble flag, with load, zero and sync reset.
module pipe_entry_reg #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              zero_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              bubble_i,
  output logic [DATA_W-1:0] data_o,
  output logic              bubble_o
);

  // Reset and zero share one clear path; zero wins over load.
  always_ff @(posedge clk_i) begin
    if (rst_i || zero_i) begin
      data_o   <= '0;
      bubble_o <= 1'b0;
    end else if (load_i) begin
      data_o   <= data_i;
      bubble_o <= bubble_i;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry skid pipeline stage (main + skid) with stall, flush and a
// saturating count of entries discarded by flush.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W     = 64,
  parameter bit          FLUSH_ZERO = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_bubble_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_bubble_o,
  input  logic              out_ready_i,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  state_e            state_q, state_d;
  logic              accept, pop;
  logic              main_load, skid_load, main_from_skid, zero_en;
  logic [DATA_W-1:0] skid_data, main_data_in;
  logic              skid_bubble, main_bubble_in;
  logic [CNT_W:0]    drop_sum;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!stall_i) begin
      if (flush_i) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY:   if (accept) state_d = ONE;
          ONE: begin
            if (accept && !pop)      state_d = FULL;
            else if (pop && !accept) state_d = EMPTY;
          end
          FULL:    if (pop) state_d = ONE;
          default: state_d = EMPTY;
        endcase
      end
    end
  end

  // Handshakes are masked by stall/flush, so a frozen stage never loads.
  always_comb begin
    in_ready_o     = 1'b0;
    out_valid_o    = 1'b0;
    accept         = 1'b0;
    pop            = 1'b0;
    main_load      = 1'b0;
    skid_load      = 1'b0;
    main_from_skid = 1'b0;
    if (!stall_i && !flush_i) begin
      in_ready_o  = (state_q != FULL);
      out_valid_o = (state_q != EMPTY);
    end
    accept = in_valid_i && in_ready_o;
    pop    = out_valid_o && out_ready_i;
    case (state_q)
      EMPTY: main_load = accept;
      ONE: begin
        main_load = accept && pop;
        skid_load = accept && !pop;
      end
      FULL: begin
        main_load      = pop;
        main_from_skid = 1'b1;
      end
      default: ;
    endcase
  end

  assign zero_en        = FLUSH_ZERO && flush_i && !stall_i;
  assign main_data_in   = main_from_skid ? skid_data   : in_data_i;
  assign main_bubble_in = main_from_skid ? skid_bubble : in_bubble_i;

  pipe_entry_reg #(.DATA_W(DATA_W)) u_main (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (main_load),
    .zero_i   (zero_en),
    .data_i   (main_data_in),
    .bubble_i (main_bubble_in),
    .data_o   (out_data_o),
    .bubble_o (out_bubble_o)
  );

  pipe_entry_reg #(.DATA_W(DATA_W)) u_skid (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (skid_load),
    .zero_i   (zero_en),
    .data_i   (in_data_i),
    .bubble_i (in_bubble_i),
    .data_o   (skid_data),
    .bubble_o (skid_bubble)
  );

  assign occupancy_o = OCC_W'(state_q);

  // Extra carry bit detects overflow so the count sticks at all-ones.
  assign drop_sum = {1'b0, drop_cnt_o} + (CNT_W+1)'(occupancy_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_o <= '0;
    end else if (flush_i && !stall_i) begin
      if (drop_sum[CNT_W]) drop_cnt_o <= '1;
      else                 drop_cnt_o <= drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: a queue model predicts handshakes,
// head data, occupancy and the saturating drop count.
module tb_pipe_skid_stage;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DROP_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic              b;
    logic [DATA_W-1:0] d;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst, stall, flush, in_valid, in_bubble, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid, out_bubble;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  drop_cnt;

  ent_t        exp_q[$];
  int unsigned m_drop;
  int          n_tests = 0;
  int          n_fail  = 0;

  pipe_skid_stage #(.DATA_W(DATA_W), .FLUSH_ZERO(1'b1), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .flush_i      (flush),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .in_bubble_i  (in_bubble),
    .in_ready_o   (in_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_bubble_o (out_bubble),
    .out_ready_i  (out_ready),
    .occupancy_o  (occupancy),
    .drop_cnt_o   (drop_cnt)
  );

  always #5 clk = ~clk;

  // Advance the model with the currently driven inputs, then one clock.
  task automatic tick();
    ent_t e;
    logic acc, pp;
    if (rst) begin
      exp_q.delete();
      m_drop = 0;
    end else if (!stall) begin
      if (flush) begin
        m_drop = (m_drop + exp_q.size() > DROP_MAX) ? DROP_MAX : m_drop + exp_q.size();
        exp_q.delete();
      end else begin
        pp  = (exp_q.size() > 0) && out_ready;
        acc = in_valid && (exp_q.size() < 2);
        if (pp) void'(exp_q.pop_front());
        if (acc) begin
          e.b = in_bubble;
          e.d = in_data;
          exp_q.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = '0; in_bubble = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    n_tests++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 64'h1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", out_valid); end
    n_tests++; if (out_data !== exp_q[0].d || exp_q[0].d !== 64'h1) begin n_fail++; $display("FAIL single_data got %h want 1", out_data); end
    n_tests++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL single_occ got %0d want 1", occupancy); end
    tick();
    n_tests++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL single_drain_occ got %0d want 0", occupancy); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hA; tick();
    in_data = 64'hB; tick();
    in_valid = 1'b0;
    #1;
    n_tests++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL b2b_occ got %0d want 2", occupancy); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_in_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0].d) begin
        n_fail++; $display("FAIL b2b_order[%0d] got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_q[0].d);
      end
      tick();
    end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty got %b want 0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h5; in_bubble = 1'b1;
    tick();
    in_valid = 1'b0; in_bubble = 1'b0;
    #1;
    n_tests++; if (out_bubble !== 1'b1 || out_data !== 64'h5) begin n_fail++; $display("FAIL bubble got b=%b d=%h want b=1 d=5", out_bubble, out_data); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bubble_valid got %b want 1", out_valid); end
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_stall_flush();
    int unsigned drop_before;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'hC; tick();
    in_data = 64'hD; tick();
    drop_before = m_drop;
    stall = 1'b1; flush = 1'b1; in_data = 64'hE; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || occupancy !== 2'd2 ||
          out_data !== 64'hC || drop_cnt !== CNT_W'(drop_before)) begin
        n_fail++; $display("FAIL stall_freeze[%0d] got v=%b r=%b occ=%0d d=%h drop=%0d want v=0 r=0 occ=2 d=c drop=%0d",
                           i, out_valid, in_ready, occupancy, out_data, drop_cnt, drop_before);
      end
      tick();
    end
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b1 || out_data !== exp_q[0].d) begin n_fail++; $display("FAIL stall_release got v=%b d=%h want v=1 d=%h", out_valid, out_data, exp_q[0].d); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_mask got r=%b v=%b want 0 0", in_ready, out_valid); end
    tick();
    flush = 1'b0;
    #1;
    n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty got occ=%0d v=%b want 0 0", occupancy, out_valid); end
    n_tests++; if (out_data !== '0 || out_bubble !== 1'b0) begin n_fail++; $display("FAIL flush_zero got d=%h b=%b want 0 0", out_data, out_bubble); end
    n_tests++; if (drop_cnt !== CNT_W'(m_drop) || m_drop != 2) begin n_fail++; $display("FAIL flush_drop2 got %0d want 2", drop_cnt); end
    in_valid = 1'b1; in_data = 64'h77; tick();
    in_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0;
    #1;
    n_tests++; if (drop_cnt !== CNT_W'(m_drop)) begin n_fail++; $display("FAIL flush_drop1 got %0d want %0d", drop_cnt, m_drop); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_data   = {$urandom, $urandom};
      in_bubble = $urandom % 2;
      #1;
      n_tests++;
      if (in_ready !== (exp_q.size() < 2) || out_valid !== (exp_q.size() > 0) ||
          occupancy !== 2'(exp_q.size())) begin
        n_fail++; $display("FAIL stream_ctl[%0d] got r=%b v=%b occ=%0d want occ=%0d", i, in_ready, out_valid, occupancy, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        n_tests++;
        if (out_data !== exp_q[0].d || out_bubble !== exp_q[0].b) begin
          n_fail++; $display("FAIL stream_data[%0d] got d=%h b=%b want d=%h b=%b", i, out_data, out_bubble, exp_q[0].d, exp_q[0].b);
        end
      end
      tick();
    end
    in_valid = 1'b0; in_bubble = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

  task automatic test_reset_full();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 64'h10; tick();
    in_data = 64'h11; tick();
    in_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    #1;
    n_tests++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_full got occ=%0d v=%b r=%b want 0 0 1", occupancy, out_valid, in_ready); end
    n_tests++; if (drop_cnt !== '0) begin n_fail++; $display("FAIL rst_full_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_saturate();
    out_ready = 1'b0;
    for (int i = 0; i < (1 << CNT_W); i++) begin
      in_valid = 1'b1; in_data = 64'(i); tick(); tick();
      in_valid = 1'b0; flush = 1'b1; tick();
      flush = 1'b0;
      if (i == 126) begin
        n_tests++; if (drop_cnt !== CNT_W'(254)) begin n_fail++; $display("FAIL sat_pre got %0d want 254", drop_cnt); end
      end
    end
    n_tests++; if (drop_cnt !== CNT_W'(DROP_MAX) || m_drop != DROP_MAX) begin n_fail++; $display("FAIL sat_max got %0d want %0d", drop_cnt, DROP_MAX); end
  endtask

  initial begin
    m_drop = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_bubble();
    test_stall_flush();
    test_flush();
    test_stream();
    test_reset_full();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
